// File: rtl/uart_pkg.sv
// Shared constants and state types for the iomem UART peripheral.
package uart_pkg;

    localparam logic [7:0] UART_BASE_SEL = 8'h04;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int unsigned ST_RX_NONEMPTY = 0;
    localparam int unsigned ST_TX_BUSY     = 1;
    localparam int unsigned ST_OVERRUN     = 2;
    localparam int unsigned ST_FRAMING     = 3;
    localparam int unsigned ST_COUNT_LSB   = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received characters; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter  int unsigned FIFO_DEPTH = 16,
    localparam int unsigned AW         = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [7:0]  din_i,
    input  logic        pop_i,
    output logic [7:0]  dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/iomem_uart.sv
// Memory-mapped UART on the iomem bus: DATA/STATUS/DIV/CTRL registers,
// single-stage transmitter and a FIFO-buffered receiver.
module iomem_uart
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 139,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        ser_tx,
    input  logic        ser_rx,
    output logic        irq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic        ready_q, irq_q, rx_ie_q, overrun_q, framing_q;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  reg_sel;
    logic        sel, is_write, stall, ack, tx_busy, tx_load, fifo_pop;

    tx_state_e   tx_state_q;
    logic        ser_tx_q, tx_load_q;
    logic [7:0]  tx_byte_q, tx_shift_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;

    rx_state_e   rx_state_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [7:0]  rx_shift_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic        rx_stop_sample, rx_push, rx_frame_err, rx_overrun;

    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

    assign reg_sel  = iomem_addr[3:2];
    assign sel      = iomem_valid && !ready_q && (iomem_addr[31:24] == UART_BASE_SEL);
    assign is_write = |iomem_wstrb;
    assign tx_busy  = (tx_state_q != TX_IDLE) || tx_load_q;
    assign stall    = is_write && iomem_wstrb[0] && (reg_sel == REG_DATA) && tx_busy;
    assign ack      = sel && !stall;
    assign tx_load  = ack && iomem_wstrb[0] && (reg_sel == REG_DATA);
    assign fifo_pop = ack && !is_write && (reg_sel == REG_DATA) && !fifo_empty;

    // Stop-bit decision is combinational so the push lands on the sample edge.
    assign rx_stop_sample = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
    assign rx_push        = rx_stop_sample && rx_s2_q;
    assign rx_frame_err   = rx_stop_sample && !rx_s2_q;
    assign rx_overrun     = rx_push && fifo_full && !fifo_pop;

    always_comb begin
        rdata_d = '0;
        case (reg_sel)
            REG_DATA:   rdata_d = fifo_empty ? '1 : {24'h0, fifo_dout};
            REG_STATUS: begin
                rdata_d[ST_RX_NONEMPTY]       = !fifo_empty;
                rdata_d[ST_TX_BUSY]           = tx_busy;
                rdata_d[ST_OVERRUN]           = overrun_q;
                rdata_d[ST_FRAMING]           = framing_q;
                rdata_d[ST_COUNT_LSB +: CW]   = fifo_count;
            end
            REG_DIV:    rdata_d = {16'h0, div_q};
            REG_CTRL:   rdata_d = {31'h0, rx_ie_q};
            default:    rdata_d = '0;
        endcase
    end

    always_comb begin
        div_d = div_q;
        if (iomem_wstrb[0]) div_d[7:0]  = iomem_wdata[7:0];
        if (iomem_wstrb[1]) div_d[15:8] = iomem_wdata[15:8];
        if (div_d < 16'd2)  div_d       = 16'd2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            div_q     <= 16'(CLK_DIV);
            rx_ie_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ready_q <= ack;
            rdata_q <= ack ? rdata_d : '0;
            irq_q   <= rx_ie_q && !fifo_empty;
            if (ack && is_write && reg_sel == REG_DIV) div_q <= div_d;
            if (ack && iomem_wstrb[0] && reg_sel == REG_CTRL) rx_ie_q <= iomem_wdata[0];
            overrun_q <= rx_overrun || (overrun_q && !(ack && iomem_wstrb[0] &&
                         reg_sel == REG_STATUS && iomem_wdata[ST_OVERRUN]));
            framing_q <= rx_frame_err || (framing_q && !(ack && iomem_wstrb[0] &&
                         reg_sel == REG_STATUS && iomem_wdata[ST_FRAMING]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            ser_tx_q   <= 1'b1;
            tx_load_q  <= 1'b0;
            tx_byte_q  <= '0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_load_q <= tx_load;
            if (tx_load) tx_byte_q <= iomem_wdata[7:0];
            case (tx_state_q)
                TX_IDLE: if (tx_load_q) begin
                    tx_state_q <= TX_START;
                    ser_tx_q   <= 1'b0;
                    tx_div_q   <= div_q;
                    tx_cnt_q   <= div_q - 16'd1;
                    tx_shift_q <= tx_byte_q;
                end
                TX_START: if (tx_cnt_q == '0) begin
                    tx_state_q <= TX_DATA;
                    ser_tx_q   <= tx_shift_q[0];
                    tx_cnt_q   <= tx_div_q - 16'd1;
                    tx_bit_q   <= '0;
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                TX_DATA: if (tx_cnt_q == '0) begin
                    tx_cnt_q <= tx_div_q - 16'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_q <= TX_STOP;
                        ser_tx_q   <= 1'b1;
                    end else begin
                        tx_bit_q   <= tx_bit_q + 3'd1;
                        ser_tx_q   <= tx_shift_q[1];
                        tx_shift_q <= tx_shift_q >> 1;
                    end
                end else tx_cnt_q <= tx_cnt_q - 16'd1;
                TX_STOP: if (tx_cnt_q == '0) tx_state_q <= TX_IDLE;
                         else tx_cnt_q <= tx_cnt_q - 16'd1;
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q   <= ser_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                    rx_state_q <= RX_START;
                    rx_div_q   <= div_q;
                    rx_cnt_q   <= (div_q >> 1) - 16'd1;
                end
                RX_START: if (rx_cnt_q == '0) begin
                    if (rx_s2_q) rx_state_q <= RX_IDLE;
                    else begin
                        rx_state_q <= RX_DATA;
                        rx_cnt_q   <= rx_div_q - 16'd1;
                        rx_bit_q   <= '0;
                    end
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                RX_DATA: if (rx_cnt_q == '0) begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                    rx_cnt_q   <= rx_div_q - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                    else rx_bit_q <= rx_bit_q + 3'd1;
                end else rx_cnt_q <= rx_cnt_q - 16'd1;
                RX_STOP: if (rx_cnt_q == '0) rx_state_q <= RX_IDLE;
                         else rx_cnt_q <= rx_cnt_q - 16'd1;
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .din_i   (rx_shift_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign ser_tx      = ser_tx_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_uart.sv
// Directed bench for iomem_uart: register access, TX framing, RX FIFO,
// sticky flags, interrupt timing and reset behaviour.
module tb_iomem_uart;

    localparam logic [31:0] A_DATA   = 32'h0400_0000;
    localparam logic [31:0] A_STATUS = 32'h0400_0004;
    localparam logic [31:0] A_DIV    = 32'h0400_0008;
    localparam logic [31:0] A_CTRL   = 32'h0400_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        ser_tx;
    logic        ser_rx = 1'b1;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iomem_uart #(.CLK_DIV(139), .FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .ser_tx      (ser_tx),
        .ser_rx      (ser_rx),
        .irq         (irq)
    );

    task automatic bus(input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        while (!done) begin
            @(posedge clk);
            #1;
            cycles++;
            if (iomem_ready) done = 1'b1;
            else if (cycles >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_timeout addr=%h: ready never seen within %0d cycles", addr, cycles);
                done = 1'b1;
            end
        end
        rdata       = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        int c;
        bus(addr, 4'h0, 32'h0, data, c);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        int c;
        bus(addr, 4'b0011, data, d, c);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (4) @(negedge clk);
        end
        ser_rx = stopb;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ser_tx, iomem_ready, irq} !== 3'b100 || iomem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ser_tx/ready/irq=%b rdata=%h, expected 100 and 0", {ser_tx, iomem_ready, irq}, iomem_rdata);
        end
        @(negedge clk) reset = 1'b0;
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 00000000", d); end
        rd(A_DIV, d);
        n_checks++;
        if (d !== 32'd139) begin n_fail++; $display("FAIL reset_div: got %0d expected 139", d); end
        rd(A_CTRL, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    endtask

    task automatic test_div();
        logic [31:0] d;
        wr(A_DIV, 32'd1);
        rd(A_DIV, d);
        n_checks++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL div_clamp: got %0d expected 2", d); end
        wr(A_DIV, 32'd4);
        rd(A_DIV, d);
        n_checks++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL div_write: got %0d expected 4", d); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] frame;
        logic [31:0] d;
        int c;
        frame = {1'b1, 8'h55, 1'b0};
        bus(A_DATA, 4'b0001, 32'h55, d, c);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (ser_tx !== frame[i / 4]) begin
                n_fail++;
                $display("FAIL tx_bit sample %0d: ser_tx=%b expected %b", i, ser_tx, frame[i / 4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int c;
        repeat (5) @(posedge clk);
        bus(A_DATA, 4'b0001, 32'hA3, d, c);
        bus(A_DATA, 4'b0001, 32'h3C, d, c);
        n_checks++;
        if (c != 42) begin n_fail++; $display("FAIL tx_stall_cycles: ack after %0d cycles expected 42", c); end
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL tx_busy_status: got %h expected 00000002", d); end
        repeat (45) @(posedge clk);
    endtask

    task automatic test_rx_basic();
        logic [31:0] d;
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_0301) begin n_fail++; $display("FAIL rx_count3: got %h expected 00000301", d); end
        for (int i = 0; i < 3; i++) begin
            rd(A_DATA, d);
            n_checks++;
            if (d !== 32'h41 + i) begin n_fail++; $display("FAIL rx_data %0d: got %h expected %h", i, d, 32'h41 + i); end
        end
        rd(A_DATA, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rx_empty_read: got %h expected ffffffff", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_1005) begin n_fail++; $display("FAIL overrun_set: got %h expected 00001005", d); end
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_1001) begin n_fail++; $display("FAIL overrun_clear: got %h expected 00001001", d); end
    endtask

    task automatic test_framing();
        logic [31:0] d;
        send_frame(8'h77, 1'b0);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_1009) begin n_fail++; $display("FAIL framing_set: got %h expected 00001009", d); end
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_1001) begin n_fail++; $display("FAIL framing_clear: got %h expected 00001001", d); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d, popped;
        fork
            send_frame(8'h30, 1'b1);
            begin
                @(negedge clk);
                repeat (39) @(negedge clk);
                rd(A_DATA, popped);
            end
        join
        n_checks++;
        if (popped !== 32'h10) begin n_fail++; $display("FAIL pushpop_data: got %h expected 00000010", popped); end
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0000_1001) begin n_fail++; $display("FAIL pushpop_status: got %h expected 00001001", d); end
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA, d);
            n_checks++;
            if (d !== ((i < 15) ? 32'h11 + i : 32'h30)) begin
                n_fail++;
                $display("FAIL drain %0d: got %h expected %h", i, d, (i < 15) ? 32'h11 + i : 32'h30);
            end
        end
        rd(A_DATA, d);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL drain_empty: got %h expected ffffffff", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        @(negedge clk) ser_rx = 1'b0;
        @(negedge clk) ser_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_status: got %h expected 00000000", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, d);
        n_checks++;
        if (d !== 32'h1 || irq !== 1'b0) begin n_fail++; $display("FAIL ctrl_ie: ctrl=%h irq=%b expected 1 and 0", d, irq); end
        fork
            send_frame(8'h5A, 1'b1);
            begin
                @(negedge clk);
                repeat (41) @(posedge clk);
                #1;
                n_checks++;
                if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: irq=%b at push cycle expected 0", irq); end
                @(posedge clk);
                #1;
                n_checks++;
                if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b one cycle after push expected 1", irq); end
            end
        join
        rd(A_DATA, d);
        n_checks++;
        if (d !== 32'h5A || irq !== 1'b1) begin n_fail++; $display("FAIL irq_read: data=%h irq=%b expected 5a and 1", d, irq); end
        @(posedge clk);
        #1;
        n_checks++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: irq=%b expected 0", irq); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        wr(A_DATA, 32'h00);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (ser_tx !== 1'b0) begin n_fail++; $display("FAIL midframe_low: ser_tx=%b expected 0", ser_tx); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ser_tx !== 1'b1) begin n_fail++; $display("FAIL midframe_reset: ser_tx=%b expected 1", ser_tx); end
        @(negedge clk) reset = 1'b0;
        rd(A_DIV, d);
        n_checks++;
        if (d !== 32'd139) begin n_fail++; $display("FAIL midframe_div: got %0d expected 139", d); end
        rd(A_STATUS, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midframe_status: got %h expected 00000000", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div();
        test_tx_frame();
        test_back_to_back();
        test_rx_basic();
        test_overrun();
        test_framing();
        test_push_pop_full();
        test_glitch();
        test_irq();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
